// File: rtl/sensor_cond_pkg.sv
// Purpose: shared defaults and widths for the sensor conditioning block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sensor_cond_pkg;

    localparam int DEB_CYCLES_DEF = 4;   // stable synchronized cycles to accept a binary change
    localparam int SAMPLE_DIV_DEF = 8;   // clock cycles between temperature samples
    localparam int AVG_LOG2_DEF   = 2;   // log2 of the number of samples averaged
    localparam int TEMP_W         = 7;   // raw and averaged temperature width
    localparam int DEB_CNT_W      = 4;   // debounce counter width, covers DEB_CYCLES up to 15
    localparam int DIV_W          = 8;   // sample divider width, covers SAMPLE_DIV up to 255

endpackage

// File: rtl/sensor_cond_debounce_cell.sv
// Purpose: 2-flop synchronizer plus debounce counter for one binary sensor.
// Latency: 2+DEB_CYCLES edges from a stable raw level to level (2 edges when BYPASS).
// Backpressure: none; level is a plain output, flip is a combinational "changes next edge" flag.
module debounce_cell
    import sensor_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter bit BYPASS     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic flip
);

    logic sync_a;
    logic sync_b;

    // Two-stage synchronizer; nothing else looks at raw.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    if (BYPASS) begin : g_bypass
        // Output follows the synchronizer directly; it changes on the next edge
        // exactly when the two stages disagree.
        assign level = sync_b;
        assign flip  = sync_a ^ sync_b;
    end else begin : g_debounce
        localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

        logic [DEB_CNT_W-1:0] cnt;
        logic                 level_q;
        logic                 differ;

        assign differ = sync_b ^ level_q;

        // Count consecutive disagreeing cycles; accept the new level on the
        // edge the count would reach DEB_CYCLES, and clear on any agreement.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt     <= '0;
                level_q <= 1'b0;
            end else if (!differ) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= sync_b;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign level = level_q;
        assign flip  = differ && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/sensor_cond.sv
// Purpose: debounce four binary sensors and average a sampled temperature (SENSOR_COND_FAST_ALARM_EN: undebounced SFA).
// Latency: binary 2+DEB_CYCLES edges; first ST update (2^AVG_LOG2)*SAMPLE_DIV+1 edges after reset release.
// Backpressure: none; outputs are levels plus single-cycle st_valid/chg pulses.
module sensor_cond
    import sensor_cond_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int AVG_LOG2   = AVG_LOG2_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              raw_SFD,
    input  logic              raw_SRD,
    input  logic              raw_SW,
    input  logic              raw_SFA,
    input  logic [TEMP_W-1:0] raw_ST,
    output logic              SFD,
    output logic              SRD,
    output logic              SW,
    output logic              SFA,
    output logic [TEMP_W-1:0] ST,
    output logic              st_valid,
    output logic              chg
);

`ifdef SENSOR_COND_FAST_ALARM_EN
    localparam bit FAST_ALARM = 1'b1;
`else
    localparam bit FAST_ALARM = 1'b0;
`endif

    // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples.
    localparam int                ACC_W     = TEMP_W + AVG_LOG2;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [AVG_LOG2:0] SAMP_FULL = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

    logic flip_sfd;
    logic flip_srd;
    logic flip_sw;
    logic flip_sfa;

    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .BYPASS(1'b0)) u_deb_sfd (
        .clk(Clk), .rst_n(Rst), .raw(raw_SFD), .level(SFD), .flip(flip_sfd)
    );

    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .BYPASS(1'b0)) u_deb_srd (
        .clk(Clk), .rst_n(Rst), .raw(raw_SRD), .level(SRD), .flip(flip_srd)
    );

    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .BYPASS(1'b0)) u_deb_sw (
        .clk(Clk), .rst_n(Rst), .raw(raw_SW), .level(SW), .flip(flip_sw)
    );

    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .BYPASS(FAST_ALARM)) u_deb_sfa (
        .clk(Clk), .rst_n(Rst), .raw(raw_SFA), .level(SFA), .flip(flip_sfa)
    );

    // One pulse on the same edge any conditioned level changes, however many change.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            chg <= 1'b0;
        end else begin
            chg <= flip_sfd | flip_srd | flip_sw | flip_sfa;
        end
    end

    logic [TEMP_W-1:0] t_s1;
    logic [TEMP_W-1:0] t_s2;
    logic [DIV_W-1:0]  div;
    logic [ACC_W-1:0]  acc;
    logic [AVG_LOG2:0] samp_cnt;

    // Double register the quasi-static temperature bus.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            t_s1 <= '0;
            t_s2 <= '0;
        end else begin
            t_s1 <= raw_ST;
            t_s2 <= t_s1;
        end
    end

    // Sample divider, accumulator and averaged output. The publish edge is the
    // edge after the last sample lands; SAMPLE_DIV >= 2 guarantees it never
    // coincides with a divider wrap, so no sample is lost when clearing.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            div      <= '0;
            acc      <= '0;
            samp_cnt <= '0;
            ST       <= '0;
            st_valid <= 1'b0;
        end else begin
            st_valid <= 1'b0;

            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end

            if (samp_cnt == SAMP_FULL) begin
                ST       <= acc[ACC_W-1:AVG_LOG2];
                st_valid <= 1'b1;
                acc      <= '0;
                samp_cnt <= '0;
            end else if (div == DIV_LAST) begin
                acc      <= acc + ACC_W'(t_s2);
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_cond.sv
// Purpose: self-checking bench for sensor_cond with default parameters.
// Latency: expected pulses are queued with their edge number and compared when the DUT pulses.
// Backpressure: n/a.
module tb_sensor_cond;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       raw_SFD = 1'b0;
    logic       raw_SRD = 1'b0;
    logic       raw_SW  = 1'b0;
    logic       raw_SFA = 1'b0;
    logic [6:0] raw_ST  = 7'd0;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       st_valid;
    logic       chg;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // edges since the last reset release; first high edge is 1
    bit st_en  = 1'b0;

    typedef struct {
        int         edge_no;
        logic [3:0] outs;
    } chg_exp_t;

    typedef struct {
        int         edge_no;
        logic [6:0] val;
    } st_exp_t;

    chg_exp_t chg_q[$];
    st_exp_t  st_q[$];
    chg_exp_t mon_ce;
    st_exp_t  mon_se;

    sensor_cond dut (
        .Clk(Clk), .Rst(Rst),
        .raw_SFD(raw_SFD), .raw_SRD(raw_SRD), .raw_SW(raw_SW), .raw_SFA(raw_SFA),
        .raw_ST(raw_ST),
        .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA),
        .ST(ST), .st_valid(st_valid), .chg(chg)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= Rst ? cyc + 1 : 0;

    // Scoreboard: every chg / st_valid pulse must match the head of its queue.
    always @(negedge Clk) begin
        if (Rst === 1'b1) begin
            if (chg === 1'b1) begin
                checks++;
                if (chg_q.size() == 0) begin
                    errors++;
                    $display("FAIL chg_unexpected: pulse at edge %0d outs %b, none expected", cyc, {SFD, SRD, SW, SFA});
                end else begin
                    mon_ce = chg_q.pop_front();
                    if (cyc != mon_ce.edge_no || {SFD, SRD, SW, SFA} !== mon_ce.outs) begin
                        errors++;
                        $display("FAIL chg_event: got edge %0d outs %b, expected edge %0d outs %b",
                                 cyc, {SFD, SRD, SW, SFA}, mon_ce.edge_no, mon_ce.outs);
                    end
                end
            end
            if (st_en && st_valid === 1'b1) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL st_unexpected: st_valid at edge %0d ST=%0d, none expected", cyc, ST);
                end else begin
                    mon_se = st_q.pop_front();
                    if (cyc != mon_se.edge_no || ST !== mon_se.val) begin
                        errors++;
                        $display("FAIL st_event: got edge %0d ST=%0d, expected edge %0d ST=%0d",
                                 cyc, ST, mon_se.edge_no, mon_se.val);
                    end
                end
            end
        end
    end

    task automatic push_chg(input int e, input logic [3:0] o);
        chg_exp_t ce;
        ce.edge_no = e;
        ce.outs    = o;
        chg_q.push_back(ce);
    endtask

    task automatic push_st(input int e, input logic [6:0] v);
        st_exp_t se;
        se.edge_no = e;
        se.val     = v;
        st_q.push_back(se);
    endtask

    task automatic wait_edge(input int n);
        int guard = 0;
        while (cyc < n && guard < 2000) begin
            @(negedge Clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_edge: at edge %0d, wanted %0d", cyc, n);
        end
    endtask

    task automatic do_reset(input logic [6:0] t);
        Rst = 1'b0;
        raw_SFD = 1'b0; raw_SRD = 1'b0; raw_SW = 1'b0; raw_SFA = 1'b0;
        raw_ST = t;
        st_en = 1'b0;
        chg_q.delete();
        st_q.delete();
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        raw_SFD = 1'b1; raw_SRD = 1'b1; raw_SW = 1'b1; raw_SFA = 1'b1;
        raw_ST = 7'd99;
        repeat (4) @(negedge Clk);
        checks++;
        if ({SFD, SRD, SW, SFA} !== 4'b0000) begin errors++; $display("FAIL reset_bin: got %b, expected 0000", {SFD, SRD, SW, SFA}); end
        checks++;
        if (ST !== 7'd0) begin errors++; $display("FAIL reset_st: got %0d, expected 0", ST); end
        checks++;
        if (st_valid !== 1'b0) begin errors++; $display("FAIL reset_st_valid: got %b, expected 0", st_valid); end
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b, expected 0", chg); end
        raw_SFD = 1'b0; raw_SRD = 1'b0; raw_SW = 1'b0; raw_SFA = 1'b0;
        raw_ST = 7'd0;
        Rst = 1'b1;
        wait_edge(20);
        checks++;
        if ({SFD, SRD, SW, SFA} !== 4'b0000) begin errors++; $display("FAIL reset_ignored_bin: got %b, expected 0000", {SFD, SRD, SW, SFA}); end
        checks++;
        if (ST !== 7'd0) begin errors++; $display("FAIL reset_ignored_st: got %0d, expected 0", ST); end
    endtask

    task automatic test_debounce();
        do_reset(7'd0);
        wait_edge(10);
        push_chg(16, 4'b1000);
        raw_SFD = 1'b1;
        wait_edge(15);
        checks++;
        if (SFD !== 1'b0) begin errors++; $display("FAIL deb_early: SFD=%b at edge 15, expected 0", SFD); end
        wait_edge(16);
        checks++;
        if (SFD !== 1'b1) begin errors++; $display("FAIL deb_rise: SFD=%b at edge 16, expected 1", SFD); end
        wait_edge(17);
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL deb_chg_width: chg=%b at edge 17, expected 0", chg); end
        wait_edge(24);
        checks++;
        if (chg_q.size() != 0) begin errors++; $display("FAIL deb_missing: %0d chg events not seen, expected 0", chg_q.size()); end
    endtask

    task automatic test_glitch();
        do_reset(7'd0);
        wait_edge(10);
        raw_SW = 1'b1;
        wait_edge(13);
        raw_SW = 1'b0;
        for (int i = 14; i <= 24; i++) begin
            wait_edge(i);
            checks++;
            if (SW !== 1'b0) begin errors++; $display("FAIL glitch_sw: SW=%b at edge %0d, expected 0", SW, i); end
        end
    endtask

    task automatic test_min_pulse();
        do_reset(7'd0);
        wait_edge(10);
        push_chg(16, 4'b0100);
        push_chg(20, 4'b0000);
        raw_SRD = 1'b1;
        wait_edge(14);
        raw_SRD = 1'b0;
        wait_edge(15);
        checks++;
        if (SRD !== 1'b0) begin errors++; $display("FAIL min_pulse_early: SRD=%b at edge 15, expected 0", SRD); end
        wait_edge(16);
        checks++;
        if (SRD !== 1'b1) begin errors++; $display("FAIL min_pulse_rise: SRD=%b at edge 16, expected 1", SRD); end
        wait_edge(19);
        checks++;
        if (SRD !== 1'b1) begin errors++; $display("FAIL min_pulse_hold: SRD=%b at edge 19, expected 1", SRD); end
        wait_edge(20);
        checks++;
        if (SRD !== 1'b0) begin errors++; $display("FAIL min_pulse_fall: SRD=%b at edge 20, expected 0", SRD); end
        wait_edge(26);
        checks++;
        if (chg_q.size() != 0) begin errors++; $display("FAIL min_pulse_missing: %0d chg events not seen, expected 0", chg_q.size()); end
    endtask

    task automatic test_fast_alarm();
        int exp_edge;
`ifdef SENSOR_COND_FAST_ALARM_EN
        exp_edge = 12;
`else
        exp_edge = 16;
`endif
        do_reset(7'd0);
        wait_edge(10);
        push_chg(exp_edge, 4'b0001);
        raw_SFA = 1'b1;
        wait_edge(exp_edge - 1);
        checks++;
        if (SFA !== 1'b0) begin errors++; $display("FAIL alarm_early: SFA=%b at edge %0d, expected 0", SFA, exp_edge - 1); end
        wait_edge(exp_edge);
        checks++;
        if (SFA !== 1'b1) begin errors++; $display("FAIL alarm_rise: SFA=%b at edge %0d, expected 1", SFA, exp_edge); end
        wait_edge(24);
        checks++;
        if (chg_q.size() != 0) begin errors++; $display("FAIL alarm_missing: %0d chg events not seen, expected 0", chg_q.size()); end
    endtask

    task automatic test_simultaneous();
        do_reset(7'd0);
        wait_edge(10);
        push_chg(16, 4'b1100);
        raw_SFD = 1'b1;
        raw_SRD = 1'b1;
        wait_edge(16);
        checks++;
        if ({SFD, SRD} !== 2'b11) begin errors++; $display("FAIL simul_rise: SFD,SRD=%b at edge 16, expected 11", {SFD, SRD}); end
        wait_edge(17);
        checks++;
        if (chg !== 1'b0) begin errors++; $display("FAIL simul_chg_width: chg=%b at edge 17, expected 0", chg); end
        wait_edge(20);
        push_chg(26, 4'b0000);
        raw_SFD = 1'b0;
        raw_SRD = 1'b0;
        wait_edge(30);
        checks++;
        if (chg_q.size() != 0) begin errors++; $display("FAIL simul_missing: %0d chg events not seen, expected 0", chg_q.size()); end
    endtask

    task automatic test_temp();
        do_reset(7'd25);
        st_en = 1'b1;
        push_st(33, 7'd25);
        push_st(65, 7'd21);   // (20+21+22+23)>>2 = 86>>2
        wait_edge(32);
        checks++;
        if (st_valid !== 1'b0 || ST !== 7'd0) begin errors++; $display("FAIL temp_early: st_valid=%b ST=%0d at edge 32, expected 0/0", st_valid, ST); end
        wait_edge(33);
        raw_ST = 7'd20;
        wait_edge(40);
        raw_ST = 7'd21;
        wait_edge(48);
        raw_ST = 7'd22;
        checks++;
        if (ST !== 7'd25) begin errors++; $display("FAIL temp_hold: ST=%0d at edge 48, expected 25", ST); end
        wait_edge(56);
        raw_ST = 7'd23;
        wait_edge(70);
        checks++;
        if (st_q.size() != 0) begin errors++; $display("FAIL temp_missing: %0d st events not seen, expected 0", st_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset(7'd100);
        st_en = 1'b1;
        wait_edge(19);
        // Reset sampled low on absolute edges 20..22; absolute edge 55 is relative edge 33.
        Rst = 1'b0;
        raw_ST = 7'd10;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        push_st(33, 7'd10);
        wait_edge(32);
        checks++;
        if (st_valid !== 1'b0 || ST !== 7'd0) begin errors++; $display("FAIL mid_reset_early: st_valid=%b ST=%0d at abs edge 54, expected 0/0", st_valid, ST); end
        wait_edge(40);
        checks++;
        if (st_q.size() != 0) begin errors++; $display("FAIL mid_reset_missing: %0d st events not seen, expected 0", st_q.size()); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_min_pulse();
        test_fast_alarm();
        test_simultaneous();
        test_temp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_cond.md
SENSOR_COND -- requirements
Module: sensor_cond

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable cycles needed to accept a binary-sensor change; legal range 1-15.
REQ-002 Parameter SAMPLE_DIV, default 8: clock cycles between temperature samples; legal range 2-255.
REQ-003 Parameter AVG_LOG2, default 2: log2 of the number of temperature samples averaged; legal range 0-3.
REQ-004 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-low.
REQ-006 raw_SFD, raw_SRD, raw_SW, raw_SFA  input  1 each  raw front-door, rear-door, window and fire-alarm sensors.
REQ-007 raw_ST  input  7  raw unsigned temperature.
REQ-008 SFD, SRD, SW, SFA  output  1 each  conditioned sensor levels for the home controller.
REQ-009 ST  output  7  averaged temperature.
REQ-010 st_valid  output  1  one-cycle pulse when ST updates.
REQ-011 chg  output  1  one-cycle pulse when any conditioned binary output changes.

Function
REQ-012 Each binary input shall pass through a 2-flop synchronizer before any other logic.
REQ-013 Each binary input shall have its own debounce counter:
- Counter clears while the synchronized value equals the output.
- Counter increments while the two differ.
- Output takes the synchronized value, and the counter clears, on the edge where the counter would reach DEB_CYCLES.
REQ-014 Latency: a raw level held stable from edge k shall appear on its output at edge k+2+DEB_CYCLES.
REQ-015 A glitch shorter than DEB_CYCLES synchronized cycles shall not change the output; any return to equality clears the counter.
REQ-016 raw_ST shall be registered twice; it is treated as quasi-static and needs no Gray coding.
REQ-017 Divider counter:
- Counts 0 to SAMPLE_DIV-1 and wraps.
- On the wrap cycle, the registered raw_ST is added to the accumulator (width 7+AVG_LOG2, so it cannot overflow) and the sample count increments.
REQ-018 Averaging:
- On the edge the sample count reaches 2^AVG_LOG2, ST shall load accumulator>>AVG_LOG2 (truncating).
- On the same edge, st_valid shall be 1 for exactly one cycle, and the accumulator and sample count shall clear.
REQ-019 ST shall hold its value between updates.
REQ-020 The first st_valid after reset shall occur on edge (2^AVG_LOG2)*SAMPLE_DIV+1 after Rst is released.
REQ-021 chg shall assert in the same cycle as any SFD/SRD/SW/SFA output change; simultaneous changes on several inputs give a single one-cycle pulse.
REQ-022 Input changes during reset shall be ignored; counting restarts from 0 on the first edge with Rst high.

Reset
REQ-023 While Rst is low at a rising edge, the following shall clear to 0: SFD, SRD, SW, SFA, ST, st_valid, chg, the synchronizers, the debounce counters, the divider, the accumulator and the sample count.
REQ-024 Reset asserted mid-average shall discard the partial accumulation; no st_valid pulse shall occur for it.

Configuration
REQ-025 Macro SENSOR_COND_FAST_ALARM_EN:
- Defined: SFA bypasses its debounce counter and equals the synchronized raw_SFA (latency 2 edges). SFA changes still contribute to chg.
- Undefined: SFA is debounced like the other binary inputs, per REQ-013/014.

Structure
REQ-026 Shared package sensor_cond_pkg shall hold the DEB_CYCLES, SAMPLE_DIV and AVG_LOG2 defaults, the temperature width constant (7), and the debounce counter width constant (4).
REQ-027 Sub-module debounce_cell (synchronizer + counter + output flop) shall be instantiated once per binary input; the temperature path stays in sensor_cond.

Verification (default parameters unless stated)
REQ-028 Release Rst, then raw_SFD 0->1 held at edge 10 -> SFD=1 at edge 16; chg pulses at edge 16 only.
REQ-029 raw_SW high for 3 cycles, then low -> SW stays 0; chg never asserts.
REQ-030 raw_ST held at 25 from reset release -> st_valid at edge 33 with ST=25. Then samples 20, 21, 22, 23 -> ST=21 (86>>2).
REQ-031 raw_SFA 0->1 at edge 10:
- Macro defined: SFA=1 at edge 12.
- Macro undefined: SFA=1 at edge 16.
REQ-032 raw_SFD and raw_SRD rise on the same edge -> both outputs rise together; chg is a single one-cycle pulse.
REQ-033 Rst asserted at edge 20 of an average and released at edge 22 -> no st_valid before edge 55; the first average uses only post-reset samples.
